edc_scrub_arbiter: RTL and testbench
====================================

// Module: edc_scrub_arbiter
// PURPOSE
//  Sits directly upstream of the EDC memory (edc_mod): Wishbone slave to the host, Wishbone master to EDC.
//  Forwards host accesses. While the bus is idle, it runs a background scrubber: read line, write corrected data back.
//  The write-back regenerates ECC and clears latent single-bit errors. Counts uncorrectable errors.
// PARAMETERS
//  WB_DWIDTH       128           data width; scrub address step = WB_DWIDTH/8
//  WB_SWIDTH       16            byte-select width (WB_DWIDTH/8)
//  SCRUB_INTERVAL  1024          consecutive idle cycles before one scrub op (>=2)
//  SCRUB_BASE      32'h0000_0000 first scrubbed address (step-aligned)
// PORTS
//  i_clk         in   1          clock
//  i_rst         in   1          asynchronous active-high reset
//  i_mem_ctrl    in   1          0=128MB (limit 0x07FF_FFFF), 1=32MB (limit 0x01FF_FFFF)
//  i_scrub_en    in   1          enable background scrubbing
//  i_wb_adr      in   32         host address
//  i_wb_sel      in   WB_SWIDTH  host byte selects
//  i_wb_we       in   1          host write enable
//  i_wb_dat      in   WB_DWIDTH  host write data
//  o_wb_dat      out  WB_DWIDTH  host read data (registered)
//  i_wb_cyc      in   1          host cycle
//  i_wb_stb      in   1          host strobe
//  o_wb_ack      out  1          host ack, 1-cycle pulse
//  o_wb_err      out  1          host error, 1-cycle pulse (instead of ack)
//  o_edc_adr/sel/we/dat  out  32/WB_SWIDTH/1/WB_DWIDTH  registered master request to EDC
//  o_edc_cyc     out  1          master cycle
//  o_edc_stb     out  1          master strobe
//  i_edc_dat     in   WB_DWIDTH  corrected read data from EDC
//  i_edc_ack     in   1          EDC ack
//  i_edc_err     in   1          EDC error (memory or uncorrectable ECC)
//  o_scrub_adr   out  32         next address to scrub
//  o_scrub_pass  out  1          1-cycle pulse when the scrub pointer wraps to SCRUB_BASE
//  o_ue_count    out  16         saturating count of scrub errors
// BEHAVIOUR
//  Reset: all outputs 0 except o_scrub_adr=SCRUB_BASE. FSM=IDLE, interval counter=0. o_edc_cyc drops asynchronously.
//  FSM states: IDLE, HOST, SCRUB_RD, SCRUB_WR.
//  IDLE: if cyc&stb&!o_wb_ack&!o_wb_err -> latch adr/sel/we/dat into o_edc_*, set o_edc_cyc/stb=1, go HOST.
//   The ack guard blocks re-accepting the strobe of the just-acked access.
//   Else if i_scrub_en && counter==SCRUB_INTERVAL-1 -> o_edc_adr=o_scrub_adr, sel=all 1s, we=0, cyc/stb=1, go SCRUB_RD.
//   Counter increments only in IDLE with no host request and i_scrub_en=1. Clears to 0 on any host request or scrub start.
//   Counter is held at 0 while i_scrub_en=0.
//  HOST: wait for i_edc_ack|i_edc_err. On that cycle: drop cyc/stb, register o_wb_dat=i_edc_dat.
//   Next cycle: pulse o_wb_ack (ack) or o_wb_err (err); go IDLE.
//   Latency = EDC ack latency + 2 cycles. Host holds stb until ack (classic WB).
//  SCRUB_RD: on i_edc_ack, load o_edc_dat=i_edc_dat, we=1, keep cyc/stb, go SCRUB_WR.
//   On i_edc_err: skip write-back (never overwrite with bad data), increment o_ue_count (sat at 16'hFFFF),
//   advance pointer, drop cyc/stb, go IDLE.
//  SCRUB_WR: on ack or err: drop cyc/stb, advance pointer, go IDLE. Err increments o_ue_count.
//  Scrub RD+WR is atomic: host request arriving meanwhile waits in IDLE until the scrub finishes; host has priority otherwise.
//  Pointer advance: +WB_DWIDTH/8. Wrap condition: the pointer is at the last step-aligned address <= limit (limit set by i_mem_ctrl).
//   On wrap: pointer=SCRUB_BASE and pulse o_scrub_pass.
//   i_mem_ctrl change with pointer above new limit -> next advance wraps.
//  i_scrub_en falling mid-scrub: current op completes normally.
//  Reset mid-operation: immediate return to reset state. Partial scrub is discarded; pointer returns to SCRUB_BASE.
// CONFIGURATION
//  EDC_SCRUB_LOG_EN defined: adds ports o_ue_adr[31:0], o_ue_valid, i_ue_clr.
//   Each scrub error loads o_ue_adr with the failing address and sets sticky o_ue_valid.
//   i_ue_clr clears o_ue_valid; a simultaneous error wins. Reset: both 0.
//  Undefined: those ports and registers do not exist; all other behaviour is identical.
// TESTING
//  1 Reset, i_scrub_en=0, host write 0x100 then read 0x100 -> data matches, o_wb_ack 1 pulse each, no scrub traffic.
//  2 i_scrub_en=1, SCRUB_INTERVAL=4, idle -> RD then WR at 0x0, then 0x10 after 4 more idle cycles. o_scrub_adr steps by 0x10.
//  3 Host stb raised during SCRUB_RD -> scrub WR completes first, host access next. Host data intact, single ack.
//  4 i_edc_err forced on scrub read at 0x20 -> no write issued, o_ue_count=1. With LOG_EN: o_ue_adr=0x20, o_ue_valid=1.
//  5 i_mem_ctrl=1, pointer at 0x01FF_FFF0 -> after scrub pointer=0x0, o_scrub_pass pulses once.
//  6 Assert i_rst during SCRUB_WR -> o_edc_cyc=0 same cycle, o_ue_count=0, pointer=SCRUB_BASE, FSM IDLE.

Source files
------------

// File: rtl/edc_scrub_arbiter.sv
// edc_scrub_arbiter
//   Arbiter placed directly upstream of the EDC memory. Host Wishbone
//   accesses are forwarded one at a time; while the bus is idle a background
//   scrubber reads each line and writes the corrected data back, which
//   regenerates ECC and clears latent single-bit errors. Errors seen by the
//   scrubber are counted (saturating).
//
// Ports
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_mem_ctrl              0: 128MB (limit 0x07FF_FFFF), 1: 32MB (limit 0x01FF_FFFF)
//   i_scrub_en              enable background scrubbing
//   i_wb_*, o_wb_*          host-side Wishbone slave (classic, 1-cycle ack/err pulse)
//   o_edc_*, i_edc_*        Wishbone master towards the EDC memory
//   o_scrub_adr             next address to scrub
//   o_scrub_pass            1-cycle pulse when the scrub pointer wraps to SCRUB_BASE
//   o_ue_count              saturating count of scrub errors
//
// Optional feature (macro EDC_SCRUB_LOG_EN)
//   Adds o_ue_adr (last failing scrub address), o_ue_valid (sticky) and
//   i_ue_clr (clears o_ue_valid; a simultaneous scrub error wins).

module edc_scrub_arbiter #(
  parameter int unsigned WB_DWIDTH      = 128,
  parameter int unsigned WB_SWIDTH      = 16,
  parameter int unsigned SCRUB_INTERVAL = 1024,
  parameter logic [31:0] SCRUB_BASE     = 32'h0000_0000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_mem_ctrl,
  input  logic                 i_scrub_en,
  input  logic [31:0]          i_wb_adr,
  input  logic [WB_SWIDTH-1:0] i_wb_sel,
  input  logic                 i_wb_we,
  input  logic [WB_DWIDTH-1:0] i_wb_dat,
  output logic [WB_DWIDTH-1:0] o_wb_dat,
  input  logic                 i_wb_cyc,
  input  logic                 i_wb_stb,
  output logic                 o_wb_ack,
  output logic                 o_wb_err,
  output logic [31:0]          o_edc_adr,
  output logic [WB_SWIDTH-1:0] o_edc_sel,
  output logic                 o_edc_we,
  output logic [WB_DWIDTH-1:0] o_edc_dat,
  output logic                 o_edc_cyc,
  output logic                 o_edc_stb,
  input  logic [WB_DWIDTH-1:0] i_edc_dat,
  input  logic                 i_edc_ack,
  input  logic                 i_edc_err,
  output logic [31:0]          o_scrub_adr,
  output logic                 o_scrub_pass,
  output logic [15:0]          o_ue_count
`ifdef EDC_SCRUB_LOG_EN
  ,
  output logic [31:0]          o_ue_adr,
  output logic                 o_ue_valid,
  input  logic                 i_ue_clr
`endif
);

  localparam int unsigned STEP       = WB_DWIDTH / 8;
  localparam int unsigned CNT_W      = $clog2(SCRUB_INTERVAL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCRUB_INTERVAL - 1);
  localparam logic [31:0] STEP_INC   = 32'(STEP);
  localparam logic [31:0] STEP_MASK  = ~(STEP_INC - 32'd1);
  localparam logic [31:0] LIMIT_128M = 32'h07FF_FFFF;
  localparam logic [31:0] LIMIT_32M  = 32'h01FF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOST,
    ST_SCRUB_RD,
    ST_SCRUB_WR
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] idle_cnt;
  logic             host_pend;
  logic             host_err_q;

  logic [31:0] last_adr_c;
  logic        wrap_c;
  logic [31:0] next_ptr_c;
  logic        host_req_c;
  logic        scrub_err_c;
  logic        scrub_adv_c;
  logic [15:0] ue_inc_c;

  // Last step-aligned line inside the selected memory size.
  assign last_adr_c  = (i_mem_ctrl ? LIMIT_32M : LIMIT_128M) & STEP_MASK;
  // '>=' so a pointer left above a freshly reduced limit wraps on its next advance.
  assign wrap_c      = (o_scrub_adr >= last_adr_c);
  assign next_ptr_c  = wrap_c ? SCRUB_BASE : (o_scrub_adr + STEP_INC);
  // Ack/err guard keeps the just-completed access from being accepted twice.
  assign host_req_c  = i_wb_cyc && i_wb_stb && !o_wb_ack && !o_wb_err;
  assign scrub_err_c = ((state == ST_SCRUB_RD) || (state == ST_SCRUB_WR)) && i_edc_err;
  assign scrub_adv_c = ((state == ST_SCRUB_RD) && i_edc_err) ||
                       ((state == ST_SCRUB_WR) && (i_edc_ack || i_edc_err));
  assign ue_inc_c    = (o_ue_count == 16'hFFFF) ? o_ue_count : (o_ue_count + 16'd1);

  // Arbitration / scrub FSM with registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      idle_cnt     <= '0;
      host_pend    <= 1'b0;
      host_err_q   <= 1'b0;
      o_wb_dat     <= '0;
      o_wb_ack     <= 1'b0;
      o_wb_err     <= 1'b0;
      o_edc_adr    <= '0;
      o_edc_sel    <= '0;
      o_edc_we     <= 1'b0;
      o_edc_dat    <= '0;
      o_edc_cyc    <= 1'b0;
      o_edc_stb    <= 1'b0;
      o_scrub_adr  <= SCRUB_BASE;
      o_scrub_pass <= 1'b0;
      o_ue_count   <= '0;
    end else begin
      o_wb_ack     <= 1'b0;
      o_wb_err     <= 1'b0;
      o_scrub_pass <= 1'b0;

      if (scrub_err_c) begin
        o_ue_count <= ue_inc_c;
      end
      if (scrub_adv_c) begin
        o_scrub_adr  <= next_ptr_c;
        o_scrub_pass <= wrap_c;
      end

      case (state)
        ST_IDLE: begin
          if (host_req_c) begin
            o_edc_adr <= i_wb_adr;
            o_edc_sel <= i_wb_sel;
            o_edc_we  <= i_wb_we;
            o_edc_dat <= i_wb_dat;
            o_edc_cyc <= 1'b1;
            o_edc_stb <= 1'b1;
            idle_cnt  <= '0;
            state     <= ST_HOST;
          end else if (i_scrub_en) begin
            if (idle_cnt == CNT_LAST) begin
              o_edc_adr <= o_scrub_adr;
              o_edc_sel <= '1;
              o_edc_we  <= 1'b0;
              o_edc_cyc <= 1'b1;
              o_edc_stb <= 1'b1;
              idle_cnt  <= '0;
              state     <= ST_SCRUB_RD;
            end else begin
              idle_cnt <= idle_cnt + CNT_W'(1);
            end
          end else begin
            idle_cnt <= '0;
          end
        end

        // Two phases: capture the EDC response, then pulse ack/err to the host.
        ST_HOST: begin
          if (host_pend) begin
            o_wb_ack  <= !host_err_q;
            o_wb_err  <= host_err_q;
            host_pend <= 1'b0;
            state     <= ST_IDLE;
          end else if (i_edc_ack || i_edc_err) begin
            o_edc_cyc  <= 1'b0;
            o_edc_stb  <= 1'b0;
            o_wb_dat   <= i_edc_dat;
            host_err_q <= i_edc_err;
            host_pend  <= 1'b1;
          end
        end

        // A failed read is never written back.
        ST_SCRUB_RD: begin
          if (i_edc_err) begin
            o_edc_cyc <= 1'b0;
            o_edc_stb <= 1'b0;
            state     <= ST_IDLE;
          end else if (i_edc_ack) begin
            o_edc_dat <= i_edc_dat;
            o_edc_we  <= 1'b1;
            state     <= ST_SCRUB_WR;
          end
        end

        ST_SCRUB_WR: begin
          if (i_edc_ack || i_edc_err) begin
            o_edc_cyc <= 1'b0;
            o_edc_stb <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef EDC_SCRUB_LOG_EN
  // Failing-address log; an error in the same cycle as a clear keeps valid set.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ue_adr   <= '0;
      o_ue_valid <= 1'b0;
    end else if (scrub_err_c) begin
      o_ue_adr   <= o_scrub_adr;
      o_ue_valid <= 1'b1;
    end else if (i_ue_clr) begin
      o_ue_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_edc_scrub_arbiter.sv
// Scoreboard bench for edc_scrub_arbiter: expected host responses and
// expected EDC bus transactions are queued by the stimulus; two monitors pop
// and compare whenever the DUT presents a response / EDC transaction.
// A second instance with a high SCRUB_BASE exercises pointer wrap.

module tb_edc_scrub_arbiter;

  localparam logic [31:0] HI_BASE = 32'h01FF_FFE0;
  localparam int W_SADR = 0;
  localparam int W_UE   = 1;
  localparam int W_RD   = 2;
  localparam int W_WR   = 3;
  localparam int W_HI   = 4;

  typedef struct {
    logic         err;
    logic         chk;
    logic [127:0] dat;
  } host_t;

  typedef struct {
    logic [31:0]  adr;
    logic         we;
    logic [15:0]  sel;
    logic [127:0] dat;
  } edc_t;

  logic         clk;
  logic         rst;
  logic         mem_ctrl, scrub_en;
  logic [31:0]  wb_adr;
  logic [15:0]  wb_sel;
  logic         wb_we, wb_cyc, wb_stb;
  logic [127:0] wb_wdat, wb_rdat;
  logic         wb_ack, wb_err;
  logic [31:0]  edc_adr;
  logic [15:0]  edc_sel;
  logic         edc_we, edc_cyc, edc_stb;
  logic [127:0] edc_wdat, edc_rdat;
  logic         edc_ack, edc_err;
  logic [31:0]  scrub_adr;
  logic         scrub_pass;
  logic [15:0]  ue_count;
`ifdef EDC_SCRUB_LOG_EN
  logic [31:0]  ue_adr, hi_ue_adr;
  logic         ue_valid, ue_clr, hi_ue_valid;
`endif

  logic         hi_mem_ctrl, hi_en;
  logic [127:0] hi_wb_dat, hi_edc_dat;
  logic         hi_wb_ack, hi_wb_err;
  logic [31:0]  hi_edc_adr, hi_scrub_adr;
  logic [15:0]  hi_edc_sel, hi_ue_count;
  logic         hi_edc_we, hi_edc_cyc, hi_edc_stb, hi_edc_ack, hi_scrub_pass;

  logic         inj_en, keep_mem;
  logic [31:0]  inj_adr;
  logic [127:0] mem [256];
  logic [255:0] vld;

  host_t exp_host[$];
  edc_t  exp_edc[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    hi_pass_cnt = 0;

  edc_scrub_arbiter #(.WB_DWIDTH(128), .WB_SWIDTH(16), .SCRUB_INTERVAL(4),
                      .SCRUB_BASE(32'h0)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_mem_ctrl(mem_ctrl), .i_scrub_en(scrub_en),
    .i_wb_adr(wb_adr), .i_wb_sel(wb_sel), .i_wb_we(wb_we), .i_wb_dat(wb_wdat),
    .o_wb_dat(wb_rdat), .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb),
    .o_wb_ack(wb_ack), .o_wb_err(wb_err),
    .o_edc_adr(edc_adr), .o_edc_sel(edc_sel), .o_edc_we(edc_we), .o_edc_dat(edc_wdat),
    .o_edc_cyc(edc_cyc), .o_edc_stb(edc_stb),
    .i_edc_dat(edc_rdat), .i_edc_ack(edc_ack), .i_edc_err(edc_err),
    .o_scrub_adr(scrub_adr), .o_scrub_pass(scrub_pass), .o_ue_count(ue_count)
`ifdef EDC_SCRUB_LOG_EN
    , .o_ue_adr(ue_adr), .o_ue_valid(ue_valid), .i_ue_clr(ue_clr)
`endif
  );

  edc_scrub_arbiter #(.WB_DWIDTH(128), .WB_SWIDTH(16), .SCRUB_INTERVAL(2),
                      .SCRUB_BASE(HI_BASE)) u_hi (
    .i_clk(clk), .i_rst(rst), .i_mem_ctrl(hi_mem_ctrl), .i_scrub_en(hi_en),
    .i_wb_adr(32'h0), .i_wb_sel(16'h0), .i_wb_we(1'b0), .i_wb_dat(128'h0),
    .o_wb_dat(hi_wb_dat), .i_wb_cyc(1'b0), .i_wb_stb(1'b0),
    .o_wb_ack(hi_wb_ack), .o_wb_err(hi_wb_err),
    .o_edc_adr(hi_edc_adr), .o_edc_sel(hi_edc_sel), .o_edc_we(hi_edc_we), .o_edc_dat(hi_edc_dat),
    .o_edc_cyc(hi_edc_cyc), .o_edc_stb(hi_edc_stb),
    .i_edc_dat(128'h0), .i_edc_ack(hi_edc_ack), .i_edc_err(1'b0),
    .o_scrub_adr(hi_scrub_adr), .o_scrub_pass(hi_scrub_pass), .o_ue_count(hi_ue_count)
`ifdef EDC_SCRUB_LOG_EN
    , .o_ue_adr(hi_ue_adr), .o_ue_valid(hi_ue_valid), .i_ue_clr(1'b0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] pat(input logic [31:0] adr);
    return {4{adr ^ 32'hA5A5_5A5A}};
  endfunction

  function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] nw,
                                         input logic [15:0] sel);
    logic [127:0] r;
    r = old;
    for (int b = 0; b < 16; b++) if (sel[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // EDC memory model: one response per request, one cycle after it appears.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      edc_ack  <= 1'b0;
      edc_err  <= 1'b0;
      edc_rdat <= '0;
      if (!keep_mem) vld <= '0;
    end else begin
      edc_ack <= 1'b0;
      edc_err <= 1'b0;
      if (edc_cyc && edc_stb && !edc_ack && !edc_err) begin
        if (!edc_we && inj_en && (edc_adr == inj_adr)) begin
          edc_err <= 1'b1;
        end else begin
          edc_ack <= 1'b1;
          if (edc_we) begin
            mem[edc_adr[11:4]] <= merge(vld[edc_adr[11:4]] ? mem[edc_adr[11:4]] : pat(edc_adr),
                                        edc_wdat, edc_sel);
            vld[edc_adr[11:4]] <= 1'b1;
          end else begin
            edc_rdat <= vld[edc_adr[11:4]] ? mem[edc_adr[11:4]] : pat(edc_adr);
          end
        end
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) hi_edc_ack <= 1'b0;
    else     hi_edc_ack <= hi_edc_cyc && hi_edc_stb && !hi_edc_ack;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_e(input logic [31:0] adr, input logic we, input logic [15:0] sel,
                       input logic [127:0] dat);
    edc_t e;
    e.adr = adr; e.we = we; e.sel = sel; e.dat = dat;
    exp_edc.push_back(e);
  endtask

  task automatic exp_h(input logic err, input logic c, input logic [127:0] dat);
    host_t h;
    h.err = err; h.chk = c; h.dat = dat;
    exp_host.push_back(h);
  endtask

  // Host response monitor.
  initial forever begin
    host_t h;
    @(negedge clk);
    if (wb_ack || wb_err) begin
      if (exp_host.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL host_unexpected: got ack=%b err=%b expected no response", wb_ack, wb_err);
      end else begin
        h = exp_host.pop_front();
        chk("host_err_flag", wb_err, h.err);
        chk("host_ack_flag", wb_ack, !h.err);
        if (h.chk) chk("host_rdata", wb_rdat, h.dat);
      end
    end
  end

  // EDC transaction monitor.
  initial forever begin
    edc_t e;
    @(negedge clk);
    if ((edc_ack || edc_err) && edc_cyc && edc_stb) begin
      if (exp_edc.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL edc_unexpected: got adr=%h we=%b expected no transaction", edc_adr, edc_we);
      end else begin
        e = exp_edc.pop_front();
        chk("edc_adr", edc_adr, e.adr);
        chk("edc_we", edc_we, e.we);
        chk("edc_sel", edc_sel, e.sel);
        if (e.we) chk("edc_wdat", edc_wdat, e.dat);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (hi_scrub_pass) hi_pass_cnt++;
  end

  task automatic wait_for(input int what, input logic [31:0] val, input string name);
    logic hit;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      case (what)
        W_SADR:  hit = (scrub_adr == val);
        W_UE:    hit = (ue_count == val[15:0]);
        W_RD:    hit = edc_cyc && edc_stb && !edc_we;
        W_WR:    hit = edc_cyc && edc_stb && edc_we;
        default: hit = (hi_scrub_adr == val);
      endcase
      if (hit) return;
    end
    n_checks++; n_errors++;
    $display("FAIL %s: got timeout expected event (value %h)", name, val);
  endtask

  task automatic host_xfer(input logic we, input logic [31:0] adr, input logic [127:0] dat,
                           input logic [15:0] sel, output int lat);
    wb_we = we; wb_adr = adr; wb_wdat = dat; wb_sel = sel;
    wb_cyc = 1'b1; wb_stb = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!(wb_ack || wb_err) && lat < 100);
    if (!(wb_ack || wb_err)) begin
      n_checks++; n_errors++;
      $display("FAIL host_timeout: got no ack after %0d cycles expected ack", lat);
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
  endtask

  initial begin
    logic [127:0] d1, d3;
    int lat, gap;
    d1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    d3 = 128'hDEAD_BEEF_0BAD_F00D_CAFE_BABE_1357_9BDF;
    rst = 1'b1; keep_mem = 1'b0; mem_ctrl = 1'b0; scrub_en = 1'b0;
    wb_adr = '0; wb_sel = '0; wb_we = 1'b0; wb_wdat = '0; wb_cyc = 1'b0; wb_stb = 1'b0;
    hi_mem_ctrl = 1'b1; hi_en = 1'b0; inj_en = 1'b0; inj_adr = '0;
`ifdef EDC_SCRUB_LOG_EN
    ue_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wb_ack", wb_ack, 0);
    chk("rst_edc_cyc", edc_cyc, 0);
    chk("rst_scrub_adr", scrub_adr, 0);
    chk("rst_ue_count", ue_count, 0);
    chk("rst_hi_scrub_adr", hi_scrub_adr, HI_BASE);
    rst = 1'b0; keep_mem = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Host write then read with scrubbing disabled.
    exp_e(32'h100, 1'b1, 16'h00FF, d1); exp_h(1'b0, 1'b0, '0);
    host_xfer(1'b1, 32'h100, d1, 16'h00FF, lat);
    chk("host_wr_latency", lat, 4);
    exp_e(32'h100, 1'b0, 16'hFFFF, '0); exp_h(1'b0, 1'b1, merge(pat(32'h100), d1, 16'h00FF));
    host_xfer(1'b0, 32'h100, '0, 16'hFFFF, lat);
    repeat (20) @(posedge clk);
    #1;
    chk("no_scrub_when_disabled", scrub_adr, 0);

    // Background scrub: RD/WR at 0x0 then 0x10, four idle cycles apart.
    exp_e(32'h00, 1'b0, 16'hFFFF, '0); exp_e(32'h00, 1'b1, 16'hFFFF, pat(32'h00));
    exp_e(32'h10, 1'b0, 16'hFFFF, '0); exp_e(32'h10, 1'b1, 16'hFFFF, pat(32'h10));
    scrub_en = 1'b1;
    wait_for(W_SADR, 32'h10, "wait_scrub_0x10");
    gap = 0;
    for (int n = 0; n < 20 && !edc_cyc; n++) begin
      @(posedge clk); #1;
      gap++;
    end
    chk("scrub_gap", gap, 4);
    wait_for(W_SADR, 32'h20, "wait_scrub_0x20");
    scrub_en = 1'b0;
    chk("ue_count_clean", ue_count, 0);

    // Uncorrectable error on scrub read at 0x20: no write-back.
    inj_en = 1'b1; inj_adr = 32'h20;
    exp_e(32'h20, 1'b0, 16'hFFFF, '0);
    scrub_en = 1'b1;
    wait_for(W_UE, 32'd1, "wait_ue");
    scrub_en = 1'b0;
    chk("ue_count_one", ue_count, 1);
    chk("ptr_after_err", scrub_adr, 32'h30);
`ifdef EDC_SCRUB_LOG_EN
    chk("ue_adr", ue_adr, 32'h20);
    chk("ue_valid_set", ue_valid, 1);
    ue_clr = 1'b1;
    @(posedge clk); #1;
    ue_clr = 1'b0;
    chk("ue_valid_clr", ue_valid, 0);
`endif
    repeat (10) @(posedge clk);
    #1;

    // Host read error is reported to the host but not counted.
    inj_adr = 32'h300;
    exp_e(32'h300, 1'b0, 16'hFFFF, '0); exp_h(1'b1, 1'b0, '0);
    host_xfer(1'b0, 32'h300, '0, 16'hFFFF, lat);
    chk("ue_count_host_err", ue_count, 1);
    inj_en = 1'b0;

    // Host request during scrub read waits for the write-back.
    exp_e(32'h30, 1'b0, 16'hFFFF, '0); exp_e(32'h30, 1'b1, 16'hFFFF, pat(32'h30));
    exp_e(32'h200, 1'b1, 16'hFFFF, d3); exp_h(1'b0, 1'b0, '0);
    exp_e(32'h200, 1'b0, 16'hFFFF, '0); exp_h(1'b0, 1'b1, d3);
    scrub_en = 1'b1;
    wait_for(W_RD, 32'h0, "wait_scrub_rd");
    scrub_en = 1'b0;
    host_xfer(1'b1, 32'h200, d3, 16'hFFFF, lat);
    host_xfer(1'b0, 32'h200, '0, 16'hFFFF, lat);
    chk("ptr_after_contended", scrub_adr, 32'h40);

    // Pointer wrap on the high-base instance, including a live mem_ctrl change.
    hi_en = 1'b1;
    wait_for(W_HI, 32'h01FF_FFF0, "wait_hi_f0");
    hi_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("hi_no_pass_yet", hi_pass_cnt, 0);
    hi_en = 1'b1;
    wait_for(W_HI, HI_BASE, "wait_hi_wrap");
    hi_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("hi_pass_once", hi_pass_cnt, 1);
    hi_mem_ctrl = 1'b0;
    hi_en = 1'b1;
    wait_for(W_HI, 32'h01FF_FFF0, "wait_hi_f0_128m");
    wait_for(W_HI, 32'h0200_0000, "wait_hi_past_32m");
    hi_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("hi_no_wrap_128m", hi_pass_cnt, 1);
    hi_mem_ctrl = 1'b1;
    hi_en = 1'b1;
    wait_for(W_HI, HI_BASE, "wait_hi_shrink_wrap");
    hi_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("hi_pass_after_shrink", hi_pass_cnt, 2);

    // Reset during scrub write-back.
    exp_e(32'h40, 1'b0, 16'hFFFF, '0);
    scrub_en = 1'b1;
    wait_for(W_WR, 32'h0, "wait_scrub_wr");
    rst = 1'b1;
    #1;
    chk("rst_async_cyc", edc_cyc, 0);
    chk("rst_ue_count_mid", ue_count, 0);
    chk("rst_scrub_adr_mid", scrub_adr, 0);
    scrub_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle", edc_cyc, 0);
    exp_e(32'h100, 1'b0, 16'hFFFF, '0); exp_h(1'b0, 1'b1, merge(pat(32'h100), d1, 16'h00FF));
    host_xfer(1'b0, 32'h100, '0, 16'hFFFF, lat);
    exp_e(32'h00, 1'b0, 16'hFFFF, '0); exp_e(32'h00, 1'b1, 16'hFFFF, pat(32'h00));
    scrub_en = 1'b1;
    wait_for(W_SADR, 32'h10, "wait_post_rst_scrub");
    scrub_en = 1'b0;

    repeat (10) @(posedge clk);
    #1;
    chk("host_queue_drained", exp_host.size(), 0);
    chk("edc_queue_drained", exp_edc.size(), 0);
    chk("hi_no_host_resp", {hi_wb_ack, hi_wb_err}, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
